// File: rtl/lsm_pkg.sv
// Shared state encoding, instruction field positions and helpers for the LDM/STM sequencer.
package lsm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StXfer,
    StWrbk,
    StFin
  } lsm_state_e;

  localparam int unsigned IR_P_BIT    = 24;
  localparam int unsigned IR_U_BIT    = 23;
  localparam int unsigned IR_W_BIT    = 21;
  localparam int unsigned IR_L_BIT    = 20;
  localparam int unsigned IR_RN_LSB   = 16;
  localparam int unsigned IR_LIST_LSB = 0;

  localparam logic [31:0] WORD_BYTES = 32'd4;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/lsm_priority_encoder.sv
// Lowest-set-bit encoder: picks the next register to transfer from the pending mask.
module lsm_priority_encoder (
  input  logic [15:0] mask_i,
  output logic [3:0]  idx_o,
  output logic        valid_o
);

  always_comb begin
    idx_o = '0;
    for (int i = 15; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o = 4'(i);
      end
    end
  end

  assign valid_o = |mask_i;

endmodule

// File: rtl/lsm_sequencer.sv
// LDM/STM sequencer: walks the register list, one MFC-handshaked transfer per register.
// Optional MFC watchdog with ABORT output is built when LSM_TIMEOUT_EN is defined.
module lsm_sequencer
  import lsm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [31:0] IR,
  input  logic [31:0] BASE,
  input  logic        MFC,
  output logic        MEM_REQ,
  output logic        MEM_RW,
  output logic [31:0] MEM_ADDR,
  output logic [3:0]  REG_NUM,
  output logic        REG_WE,
  output logic        WB_EN,
  output logic [31:0] WB_VALUE,
  output logic [4:0]  LSM_COUNT,
  output logic        BUSY,
`ifdef LSM_TIMEOUT_EN
  output logic        ABORT,
`endif
  output logic        DONE
);

  lsm_state_e  state_q, state_d;
  logic [15:0] mask_q, mask_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wb_q, wb_d;
  logic [4:0]  count_q, count_d;
  logic        l_q, l_d;
  logic        wb_apply_q, wb_apply_d;
`ifdef LSM_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
  logic        abort_q, abort_d;
`endif

  logic [15:0] list_in;
  logic [3:0]  rn_in;
  logic [4:0]  n_start;
  logic [31:0] span, start_addr, wb_start;
  logic        wb_apply_start;
  logic        reg_valid;
  logic        unused_ir;

  assign list_in   = IR[IR_LIST_LSB +: 16];
  assign rn_in     = IR[IR_RN_LSB +: 4];
  assign n_start   = popcount16(list_in);
  assign span      = 32'(n_start) * WORD_BYTES;
  assign wb_start  = IR[IR_U_BIT] ? BASE + span : BASE - span;
  assign unused_ir = ^{IR[31:25], IR[22]};

  // A load that includes Rn keeps the loaded value instead of the writeback.
  assign wb_apply_start = IR[IR_W_BIT] && (n_start != 5'd0) && !(IR[IR_L_BIT] && list_in[rn_in]);

  // Transfers always ascend, so only the lowest address depends on P/U.
  always_comb begin
    unique case ({IR[IR_P_BIT], IR[IR_U_BIT]})
      2'b01:   start_addr = BASE;
      2'b11:   start_addr = BASE + WORD_BYTES;
      2'b00:   start_addr = BASE - span + WORD_BYTES;
      default: start_addr = BASE - span;
    endcase
  end

  lsm_priority_encoder u_prio (
    .mask_i  (mask_q),
    .idx_o   (REG_NUM),
    .valid_o (reg_valid)
  );

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    addr_d     = addr_q;
    wb_d       = wb_q;
    count_d    = count_q;
    l_d        = l_q;
    wb_apply_d = wb_apply_q;
`ifdef LSM_TIMEOUT_EN
    tmo_d      = tmo_q;
    abort_d    = abort_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (START) begin
          state_d    = StSetup;
          mask_d     = list_in;
          addr_d     = start_addr;
          wb_d       = wb_start;
          count_d    = n_start;
          l_d        = IR[IR_L_BIT];
          wb_apply_d = wb_apply_start;
        end
      end
      StSetup: begin
        state_d = (count_q == 5'd0) ? StFin : StXfer;
`ifdef LSM_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      StXfer: begin
        if (MFC) begin
          mask_d  = mask_q & ~(16'd1 << REG_NUM);
          addr_d  = addr_q + WORD_BYTES;
          count_d = count_q - 5'd1;
          if (count_q == 5'd1) begin
            state_d = wb_apply_q ? StWrbk : StFin;
          end
`ifdef LSM_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
`ifdef LSM_TIMEOUT_EN
        else if (tmo_q == TIMEOUT_CYCLES - 1) begin
          state_d = StFin;
          abort_d = 1'b1;
          mask_d  = '0;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
`endif
      end
      StWrbk: state_d = StFin;
      StFin: begin
        state_d = StIdle;
`ifdef LSM_TIMEOUT_EN
        abort_d = 1'b0;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= StIdle;
      mask_q     <= '0;
      addr_q     <= '0;
      wb_q       <= '0;
      count_q    <= '0;
      l_q        <= 1'b0;
      wb_apply_q <= 1'b0;
`ifdef LSM_TIMEOUT_EN
      tmo_q      <= '0;
      abort_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      addr_q     <= addr_d;
      wb_q       <= wb_d;
      count_q    <= count_d;
      l_q        <= l_d;
      wb_apply_q <= wb_apply_d;
`ifdef LSM_TIMEOUT_EN
      tmo_q      <= tmo_d;
      abort_q    <= abort_d;
`endif
    end
  end

  assign MEM_REQ   = (state_q == StXfer) && reg_valid;
  assign MEM_RW    = l_q;
  assign MEM_ADDR  = addr_q;
  assign REG_WE    = (state_q == StXfer) && MFC && l_q;
  assign WB_EN     = (state_q == StWrbk);
  assign WB_VALUE  = wb_q;
  assign LSM_COUNT = count_q;
  assign BUSY      = (state_q != StIdle);
  assign DONE      = (state_q == StFin);
`ifdef LSM_TIMEOUT_EN
  assign ABORT     = (state_q == StFin) && abort_q;
`endif

endmodule

// File: tb/tb_lsm_sequencer.sv
// Self-checking bench for lsm_sequencer: phase-list model plus directed LDM/STM scenarios.
module tb_lsm_sequencer;

  localparam int TMO     = 4;
  localparam int K_SETUP = 0;
  localparam int K_XFER  = 1;
  localparam int K_WB    = 2;
  localparam int K_DONE  = 3;

  typedef struct {
    int          kind;
    logic [3:0]  rg;
    logic [31:0] addr;
    logic [4:0]  cnt;
    bit          abort;
  } phase_t;

  logic        CLK = 1'b0;
  logic        RESET, START, MFC;
  logic [31:0] IR, BASE;
  logic        MEM_REQ, MEM_RW, REG_WE, WB_EN, BUSY, DONE;
  logic [31:0] MEM_ADDR, WB_VALUE;
  logic [3:0]  REG_NUM;
  logic [4:0]  LSM_COUNT;
`ifdef LSM_TIMEOUT_EN
  logic        ABORT;
`endif

  logic mfc_force, mfc_hold_low;
  int   mfc_delay = 0;
  int   wait_cnt  = 0;

  int n_checks = 0;
  int n_fail   = 0;

  phase_t      ph_q[$];
  logic [31:0] exp_wb;
  logic        exp_rw;
  bit          zero_expected = 1'b1;
  int          rel, tmo_cnt, hold_cnt;

  logic [31:0] obs_addr[$];
  logic [3:0]  obs_reg[$];
  int          obs_hold[$];
  int          obs_regwe, obs_wb_cnt, obs_done_cnt, obs_done_rel;
  logic [31:0] obs_wb_val;
  logic        obs_abort;

  always #5 CLK = ~CLK;

  lsm_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .IR        (IR),
    .BASE      (BASE),
    .MFC       (MFC),
    .MEM_REQ   (MEM_REQ),
    .MEM_RW    (MEM_RW),
    .MEM_ADDR  (MEM_ADDR),
    .REG_NUM   (REG_NUM),
    .REG_WE    (REG_WE),
    .WB_EN     (WB_EN),
    .WB_VALUE  (WB_VALUE),
    .LSM_COUNT (LSM_COUNT),
    .BUSY      (BUSY),
`ifdef LSM_TIMEOUT_EN
    .ABORT     (ABORT),
`endif
    .DONE      (DONE)
  );

  // Memory responder: answers after mfc_delay idle request cycles.
  assign MFC = mfc_force | (MEM_REQ & ~mfc_hold_low & (wait_cnt >= mfc_delay));

  always @(posedge CLK) begin
    if (MEM_REQ && !MFC) wait_cnt <= wait_cnt + 1;
    else                 wait_cnt <= 0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_ir(input bit p, input bit u, input bit s, input bit w,
                                        input bit l, input logic [3:0] rn,
                                        input logic [15:0] list);
    return {4'hE, 3'b100, p, u, s, w, l, rn, list};
  endfunction

  function automatic phase_t mk(input int k, input int rg, input logic [31:0] a, input int c,
                                input bit ab);
    phase_t p;
    p.kind  = k;
    p.rg    = 4'(rg);
    p.addr  = a;
    p.cnt   = 5'(c);
    p.abort = ab;
    return p;
  endfunction

  // Expected phase list for one instruction, straight from the LDM/STM rules.
  function automatic void build_model(input logic [31:0] ir, input logic [31:0] base);
    logic [15:0] list;
    logic [31:0] a, span;
    int          n, rem;
    list = ir[15:0];
    n = 0;
    for (int r = 0; r < 16; r++) if (list[r]) n++;
    span = 32'(4 * n);
    case ({ir[24], ir[23]})
      2'b01:   a = base;
      2'b11:   a = base + 4;
      2'b00:   a = base - span + 4;
      default: a = base - span;
    endcase
    exp_wb = ir[23] ? base + span : base - span;
    exp_rw = ir[20];
    ph_q.push_back(mk(K_SETUP, 0, 0, n, 1'b0));
    rem = n;
    for (int r = 0; r < 16; r++) begin
      if (list[r]) begin
        ph_q.push_back(mk(K_XFER, r, a, rem, 1'b0));
        a = a + 4;
        rem--;
      end
    end
    if (ir[21] && n > 0 && !(ir[20] && list[ir[19:16]])) ph_q.push_back(mk(K_WB, 0, 0, 0, 1'b0));
    ph_q.push_back(mk(K_DONE, 0, 0, 0, 1'b0));
  endfunction

  always @(negedge CLK) begin : cmp
    phase_t ph;
    if (ph_q.size() == 0) begin
      chk("busy_idle", 32'(BUSY), 0);
      chk("req_idle", 32'(MEM_REQ), 0);
      chk("wben_idle", 32'(WB_EN), 0);
      chk("done_idle", 32'(DONE), 0);
      chk("regwe_idle", 32'(REG_WE), 0);
`ifdef LSM_TIMEOUT_EN
      chk("abort_idle", 32'(ABORT), 0);
`endif
      if (zero_expected) begin
        chk("addr_rst", MEM_ADDR, 0);
        chk("wbval_rst", WB_VALUE, 0);
        chk("count_rst", 32'(LSM_COUNT), 0);
        chk("rw_rst", 32'(MEM_RW), 0);
        chk("regnum_rst", 32'(REG_NUM), 0);
      end
      if (START && !RESET) begin
        build_model(IR, BASE);
        rel = 0;
        hold_cnt = 0;
        tmo_cnt = 0;
        zero_expected = 1'b0;
      end
    end else begin
      rel++;
      ph = ph_q[0];
      chk("busy", 32'(BUSY), 1);
      case (ph.kind)
        K_SETUP: begin
          chk("setup_req", 32'(MEM_REQ), 0);
          chk("setup_done", 32'(DONE), 0);
          chk("setup_count", 32'(LSM_COUNT), 32'(ph.cnt));
          chk("setup_wbval", WB_VALUE, exp_wb);
          void'(ph_q.pop_front());
        end
        K_XFER: begin
          chk("xfer_req", 32'(MEM_REQ), 1);
          chk("xfer_regnum", 32'(REG_NUM), 32'(ph.rg));
          chk("xfer_addr", MEM_ADDR, ph.addr);
          chk("xfer_rw", 32'(MEM_RW), 32'(exp_rw));
          chk("xfer_count", 32'(LSM_COUNT), 32'(ph.cnt));
          chk("xfer_regwe", 32'(REG_WE), 32'(MFC & exp_rw));
          chk("xfer_wben", 32'(WB_EN), 0);
          chk("xfer_done", 32'(DONE), 0);
          hold_cnt++;
          if (MFC) begin
            obs_addr.push_back(MEM_ADDR);
            obs_reg.push_back(REG_NUM);
            obs_hold.push_back(hold_cnt);
            if (REG_WE) obs_regwe++;
            hold_cnt = 0;
            tmo_cnt = 0;
            void'(ph_q.pop_front());
          end
`ifdef LSM_TIMEOUT_EN
          else begin
            tmo_cnt++;
            if (tmo_cnt == TMO) begin
              ph_q.delete();
              ph_q.push_back(mk(K_DONE, 0, 0, 0, 1'b1));
            end
          end
`endif
        end
        K_WB: begin
          chk("wb_en", 32'(WB_EN), 1);
          chk("wb_value", WB_VALUE, exp_wb);
          chk("wb_req", 32'(MEM_REQ), 0);
          chk("wb_done", 32'(DONE), 0);
          obs_wb_cnt++;
          obs_wb_val = WB_VALUE;
          void'(ph_q.pop_front());
        end
        default: begin
          chk("fin_done", 32'(DONE), 1);
          chk("fin_wben", 32'(WB_EN), 0);
          chk("fin_req", 32'(MEM_REQ), 0);
          if (!ph.abort) chk("fin_count", 32'(LSM_COUNT), 0);
`ifdef LSM_TIMEOUT_EN
          chk("fin_abort", 32'(ABORT), 32'(ph.abort));
          obs_abort = ABORT;
`endif
          obs_done_cnt++;
          obs_done_rel = rel;
          void'(ph_q.pop_front());
        end
      endcase
    end
    if (RESET) begin
      ph_q.delete();
      zero_expected = 1'b1;
    end
  end

  task automatic launch(input logic [31:0] ir, input logic [31:0] base, input bit glitch);
    obs_addr.delete();
    obs_reg.delete();
    obs_hold.delete();
    obs_regwe    = 0;
    obs_wb_cnt   = 0;
    obs_done_cnt = 0;
    obs_done_rel = -1;
    obs_wb_val   = '0;
    obs_abort    = 1'b0;
    @(posedge CLK); #1;
    START = 1'b1;
    IR    = ir;
    BASE  = base;
    @(posedge CLK); #1;
    START = 1'b0;
    if (glitch) begin
      // A second request while busy must be ignored.
      @(posedge CLK); #1;
      START = 1'b1;
      IR    = 32'hE9BD_FFFF;
      BASE  = 32'h0;
      @(posedge CLK); #1;
      START = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (i < 200 && !(ph_q.size() == 0 && !BUSY)) begin
      @(negedge CLK); #2;
      i++;
    end
    chk("wait_idle_bound", 32'(i < 200), 1);
  endtask

  initial begin
    int i;
    RESET = 1'b1;
    START = 1'b0;
    IR = '0;
    BASE = '0;
    mfc_force = 1'b0;
    mfc_hold_low = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;

    // STMIA R0!, {R1,R3}; MFC tied high, including outside XFER
    mfc_force = 1'b1;
    launch(mk_ir(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 16'h000A), 32'h100, 1'b0);
    wait_idle();
    chk("stmia_n", 32'(obs_addr.size()), 2);
    chk("stmia_addr0", obs_addr[0], 32'h100);
    chk("stmia_addr1", obs_addr[1], 32'h104);
    chk("stmia_reg0", 32'(obs_reg[0]), 1);
    chk("stmia_reg1", 32'(obs_reg[1]), 3);
    chk("stmia_wb_cnt", 32'(obs_wb_cnt), 1);
    chk("stmia_wb_val", obs_wb_val, 32'h108);
    chk("stmia_done_rel", 32'(obs_done_rel), 5);
    mfc_force = 1'b0;

    // STMDA with slow memory, reset during the second transfer's wait
    mfc_delay = 2;
    launch(mk_ir(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 16'h0006), 32'h80, 1'b0);
    i = 0;
    while (i < 50 && obs_addr.size() < 1) begin
      @(negedge CLK); #2;
      i++;
    end
    chk("stmda_first_bound", 32'(i < 50), 1);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK); #2;
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_addr", MEM_ADDR, 0);
    chk("stmda_addr0", obs_addr[0], 32'h7C);
    chk("stmda_hold0", 32'(obs_hold[0]), 3);
    repeat (3) @(posedge CLK);
    chk("rst_n", 32'(obs_addr.size()), 1);
    chk("rst_no_done", 32'(obs_done_cnt), 0);
    chk("rst_no_wb", 32'(obs_wb_cnt), 0);
    mfc_delay = 0;

    // LDMDB R2!, {R0,R4,R15}, with an ignored START while busy
    launch(mk_ir(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 16'h8011), 32'h200, 1'b1);
    wait_idle();
    chk("ldmdb_n", 32'(obs_addr.size()), 3);
    chk("ldmdb_addr0", obs_addr[0], 32'h1F4);
    chk("ldmdb_addr1", obs_addr[1], 32'h1F8);
    chk("ldmdb_addr2", obs_addr[2], 32'h1FC);
    chk("ldmdb_reg0", 32'(obs_reg[0]), 0);
    chk("ldmdb_reg1", 32'(obs_reg[1]), 4);
    chk("ldmdb_reg2", 32'(obs_reg[2]), 15);
    chk("ldmdb_regwe", 32'(obs_regwe), 3);
    chk("ldmdb_wb_val", obs_wb_val, 32'h1F4);
    chk("ldmdb_done_rel", 32'(obs_done_rel), 6);

    // LDMIB R5!, {R5,R6} with S set: loaded Rn suppresses writeback
    launch(mk_ir(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 16'h0060), 32'h40, 1'b0);
    wait_idle();
    chk("ldmib_addr0", obs_addr[0], 32'h44);
    chk("ldmib_addr1", obs_addr[1], 32'h48);
    chk("ldmib_wb_cnt", 32'(obs_wb_cnt), 0);
    chk("ldmib_done_rel", 32'(obs_done_rel), 4);

    // Empty register list
    launch(mk_ir(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 16'h0000), 32'h300, 1'b0);
    wait_idle();
    chk("empty_n", 32'(obs_addr.size()), 0);
    chk("empty_wb_cnt", 32'(obs_wb_cnt), 0);
    chk("empty_done_rel", 32'(obs_done_rel), 2);

`ifdef LSM_TIMEOUT_EN
    // MFC never arrives: watchdog abort
    mfc_hold_low = 1'b1;
    launch(mk_ir(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0004), 32'h10, 1'b0);
    wait_idle();
    chk("tmo_abort", 32'(obs_abort), 1);
    chk("tmo_done_rel", 32'(obs_done_rel), 6);
    chk("tmo_wb_cnt", 32'(obs_wb_cnt), 0);
    chk("tmo_n", 32'(obs_addr.size()), 0);
    mfc_hold_low = 1'b0;
`endif

    repeat (3) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
